// File: rtl/lsu_rmw_if.sv
// Pipeline request/response and single-port RAM bundle for lsu_rmw.
// slave = LSU side, master = pipeline + RAM side.
interface lsu_rmw_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              is_store;
  logic [2:0]        funct;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              resp_valid;
  logic [31:0]       rdata;
  logic              misalign;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, is_store, funct,
    input  addr, wdata, mem_rdata,
    output req_ready, resp_valid, rdata,
    output misalign, mem_en, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output req_valid, is_store, funct,
    output addr, wdata, mem_rdata,
    input  req_ready, resp_valid, rdata,
    input  misalign, mem_en, mem_we,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit over a word-wide RAM; sub-word stores
// are done as read-modify-write of the containing word.
module lsu_rmw #(
  parameter int ADDR_W = 10
) (
  input  logic     clk,
  input  logic     reset,
  lsu_rmw_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_store;
  logic [2:0]        r_funct;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic [31:0]       r_rdata;
  logic              r_resp;
  logic              r_mis;

  logic              w_acc;
  logic              w_legal;
  logic              w_misal;
  logic              w_bad;
  logic              w_en;
  logic              w_we;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;
  logic [31:0]       w_merge;
  logic              w_unused;

  assign w_unused = &{1'b0, bus.addr[31:ADDR_W+2]};

  assign bus.req_ready = (r_state == IDLE);
  assign w_acc = bus.req_valid && (r_state == IDLE);

  always_comb begin
    w_legal = 1'b0;
    unique case (bus.funct)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !bus.is_store;
      default:                w_legal = 1'b0;
    endcase
    w_misal =
      ((bus.funct[1:0] == 2'b01) && bus.addr[0]) ||
      ((bus.funct[1:0] == 2'b10) &&
       (bus.addr[1:0] != 2'b00));
    w_bad = !w_legal || w_misal;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_we   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (w_bad)
            w_next = RESP;
          else if (bus.is_store &&
                   (bus.funct == 3'b010))
            w_next = WR;
          else
            w_next = RD;
        end
      end
      RD: begin
        w_en   = 1'b1;
        w_next = RD_WAIT;
      end
      RD_WAIT: w_next = r_store ? WR : RESP;
      WR: begin
        w_en   = 1'b1;
        w_we   = 1'b1;
        w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Reset gates the RAM strobes so an aborted RMW never lands.
  assign bus.mem_en    = w_en && !reset;
  assign bus.mem_we    = w_we && !reset;
  assign bus.mem_addr  = r_addr[ADDR_W+1:2];
  assign bus.mem_wdata = w_merge;

  always_comb begin
    w_byte = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = bus.mem_rdata[{r_addr[1], 4'b0000} +: 16];
    unique case (r_funct)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = r_word;
    unique case (r_funct[1:0])
      2'b00:
        w_merge[{r_addr[1:0], 3'b000} +: 8] =
          r_wdata[7:0];
      2'b01:
        w_merge[{r_addr[1], 4'b0000} +: 16] =
          r_wdata[15:0];
      default: w_merge = r_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_store <= bus.is_store;
      r_funct <= bus.funct;
      r_addr  <= bus.addr[ADDR_W+1:0];
      r_wdata <= bus.wdata;
    end
  end

  // Only the reject path goes straight from IDLE to RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word  <= '0;
      r_rdata <= '0;
      r_resp  <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      if (r_state == RD_WAIT) r_word <= bus.mem_rdata;
      r_resp  <= (w_next == RESP);
      r_mis   <= (w_next == RESP) && (r_state == IDLE);
      r_rdata <= ((w_next == RESP) &&
                  (r_state == RD_WAIT)) ? w_ext : '0;
    end
  end

  assign bus.resp_valid = r_resp;
  assign bus.rdata      = r_rdata;
  assign bus.misalign   = r_mis;

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw with a small registered-read
// RAM model; responses are checked against queued expectations.
module tb_lsu_rmw;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  lsu_rmw_if #(.ADDR_W(10)) bus ();

  lsu_rmw #(.ADDR_W(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:15] = '{
    1: 32'h8899AABB,
    2: 32'h11223344,
    default: 32'h0
  };

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[3:0]] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr[3:0]];
    end
  end

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  int   outstanding = 0;
  int   n_acc = 0;
  int   n_resp = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic [9:0]  last_wa = '0;
  logic [31:0] last_wd = '0;
  bit   auto_lw = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      outstanding = 0;
    end else begin
      if (outstanding > 0)
        chk("busy_rdy", 32'(bus.req_ready), 32'd0);
      if (bus.resp_valid) begin
        chk("resp_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rdata", bus.rdata, e.rd);
          chk("misalign", 32'(bus.misalign), 32'(e.mis));
        end
        if (outstanding > 0) outstanding--;
        n_resp++;
      end else begin
        chk("idle_rdata", bus.rdata, 32'd0);
        chk("idle_mis", 32'(bus.misalign), 32'd0);
      end
      if (bus.req_valid && bus.req_ready) begin
        outstanding++;
        n_acc++;
        if (auto_lw) q.push_back('{32'h8899AABB, 1'b0});
      end
      if (bus.mem_en && !bus.mem_we) rd_cnt++;
      if (bus.mem_en && bus.mem_we) begin
        wr_cnt++;
        last_wa = bus.mem_addr;
        last_wd = bus.mem_wdata;
      end
    end
  end

  task automatic send(input string nm,
                      input logic st,
                      input logic [2:0] f,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [31:0] er,
                      input logic em,
                      input int elat,
                      input int erd,
                      input int ewr);
    int rd0, wr0, lat;
    bit got;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.is_store  = st;
    bus.funct     = f;
    bus.addr      = a;
    bus.wdata     = wd;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk({nm, "_accept"}, 32'(got), 32'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    q.push_back('{er, em});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(posedge clk);
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_reads"}, 32'(rd_cnt - rd0), 32'(erd));
    chk({nm, "_writes"}, 32'(wr_cnt - wr0), 32'(ewr));
  endtask

  initial begin
    int a0, r0;
    bit seen;
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, r0;
    bit seen;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.is_store  = 1'b0;
    bus.funct     = 3'b000;
    bus.addr      = '0;
    bus.wdata     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_mis", 32'(bus.misalign), 32'd0);
    chk("rst_en", 32'(bus.mem_en), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    // loads from RAM[1] = 8899AABB
    send("lb7", 0, 3'b000, 32'h7, 0,
         32'hFFFFFF88, 0, 3, 1, 0);
    send("lhu6", 0, 3'b101, 32'h6, 0,
         32'h00008899, 0, 3, 1, 0);
    send("lh4", 0, 3'b001, 32'h4, 0,
         32'hFFFFAABB, 0, 3, 1, 0);
    send("lbu5", 0, 3'b100, 32'h5, 0,
         32'h000000AA, 0, 3, 1, 0);
    send("lw4", 0, 3'b010, 32'h4, 0,
         32'h8899AABB, 0, 3, 1, 0);

    // byte store read-modify-write into RAM[2]
    send("sb9", 1, 3'b000, 32'h9, 32'hFFFFFF55,
         32'h0, 0, 4, 1, 1);
    chk("sb9_wa", 32'(last_wa), 32'd2);
    chk("sb9_wd", last_wd, 32'h11225544);
    chk("sb9_ram", ram[2], 32'h11225544);

    // rejects: no RAM access, one-cycle response
    send("sw6", 1, 3'b010, 32'h6, 32'h1,
         32'h0, 1, 1, 0, 0);
    send("lh3", 0, 3'b001, 32'h3, 0,
         32'h0, 1, 1, 0, 0);
    send("ld011", 0, 3'b011, 32'h0, 0,
         32'h0, 1, 1, 0, 0);
    send("st100", 1, 3'b100, 32'h8, 0,
         32'h0, 1, 1, 0, 0);

    send("swc", 1, 3'b010, 32'hC, 32'hDEADBEEF,
         32'h0, 0, 2, 0, 1);
    chk("swc_ram", ram[3], 32'hDEADBEEF);
    send("lwc", 0, 3'b010, 32'hC, 0,
         32'hDEADBEEF, 0, 3, 1, 0);

    send("sha", 1, 3'b001, 32'hA, 32'hABCD1234,
         32'h0, 0, 4, 1, 1);
    chk("sha_ram", ram[2], 32'h12345544);
    send("lb9", 0, 3'b000, 32'h9, 0,
         32'h00000055, 0, 3, 1, 0);

    // reset lands while the RMW write is on the bus
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.is_store  = 1'b1;
    bus.funct     = 3'b001;
    bus.addr      = 32'h8;
    bus.wdata     = 32'h7777;
    q.push_back('{32'h0, 1'b0});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rstwr_reach", 32'(seen), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstwr_we", 32'(bus.mem_we), 32'd0);
    chk("rstwr_en", 32'(bus.mem_en), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstwr_resp", 32'(bus.resp_valid), 32'd0);
    chk("rstwr_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstwr_ready", 32'(bus.req_ready), 32'd1);
    chk("rstwr_ram", ram[2], 32'h12345544);
    repeat (4) @(posedge clk);
    chk("rstwr_nresp", 32'(q.size()), 32'd0);

    // back-to-back loads with req_valid held high
    a0 = n_acc;
    r0 = n_resp;
    @(posedge clk);
    #1;
    auto_lw       = 1'b1;
    bus.req_valid = 1'b1;
    bus.is_store  = 1'b0;
    bus.funct     = 3'b010;
    bus.addr      = 32'h4;
    repeat (16) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    auto_lw       = 1'b0;
    for (int i = 0; i < 10 && outstanding != 0; i++)
      @(posedge clk);
    @(negedge clk);
    chk("btb_acc", 32'(n_acc - a0), 32'd4);
    chk("btb_resp", 32'(n_resp - r0), 32'd4);
    chk("btb_drain", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
